// File: rtl/pipe_addsub_pkg.sv
// Shared types and elaboration helpers for the pipelined adder/subtractor.
// The optional overflow output is enabled by defining PIPE_ADDSUB_OVF_EN.
package pipe_addsub_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Width of one carry chunk.
    function automatic int chunk_of(input int width, input int stages);
        return width / stages;
    endfunction

    // True when the operand splits into equal, non-empty chunks.
    function automatic bit stages_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/addsub_stage.sv
// One pipeline slice: adds chunk IDX of the operands with the incoming carry
// and registers the partial result, carry and remaining operands.
// With PIPE_ADDSUB_OVF_EN defined it also registers the signed overflow of its
// chunk MSB (only meaningful in the last stage).
import pipe_addsub_pkg::*;

module addsub_stage #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_acc,
    input  logic             in_carry,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_acc,
    output logic             out_carry,
`ifdef PIPE_ADDSUB_OVF_EN
    output logic             out_ovf,
`endif
    output logic             out_sub
);

    localparam int LO = IDX * CHUNK;

    logic [CHUNK-1:0] a_chunk_s;
    logic [CHUNK-1:0] b_chunk_s;
    logic [CHUNK:0]   sum_s;
    logic [WIDTH-1:0] acc_next_s;

    assign a_chunk_s = in_a[LO +: CHUNK];
    assign b_chunk_s = in_b[LO +: CHUNK];
    assign sum_s     = {1'b0, a_chunk_s} + {1'b0, b_chunk_s} + {{CHUNK{1'b0}}, in_carry};

    // A slot is free when empty or when its occupant leaves this cycle.
    assign in_ready = !out_valid || out_ready;

    // Merge this chunk's sum bits into the partial result.
    always_comb begin
        acc_next_s = in_acc;
        acc_next_s[LO +: CHUNK] = sum_s[CHUNK-1:0];
    end

`ifdef PIPE_ADDSUB_OVF_EN
    logic cin_msb_s;
    // Carry into the chunk MSB recovered from its sum bit and operand bits.
    assign cin_msb_s = sum_s[CHUNK-1] ^ a_chunk_s[CHUNK-1] ^ b_chunk_s[CHUNK-1];

    // Overflow flag register, loaded alongside the data.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_ovf <= 1'b0;
        end else if (in_ready) begin
            out_ovf <= cin_msb_s ^ sum_s[CHUNK];
        end else begin
            out_ovf <= out_ovf;
        end
    end
`endif

    // Register slice: load from upstream when there is room, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_a     <= {WIDTH{1'b0}};
            out_b     <= {WIDTH{1'b0}};
            out_acc   <= {WIDTH{1'b0}};
            out_carry <= 1'b0;
            out_sub   <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            out_a     <= in_a;
            out_b     <= in_b;
            out_acc   <= acc_next_s;
            out_carry <= sum_s[CHUNK];
            out_sub   <= in_sub;
        end else begin
            out_valid <= out_valid;
            out_a     <= out_a;
            out_b     <= out_b;
            out_acc   <= out_acc;
            out_carry <= out_carry;
            out_sub   <= out_sub;
        end
    end

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor with valid/ready on both sides.
// The carry chain is cut into STAGES chunks, one chunk per pipeline stage.
// Define PIPE_ADDSUB_OVF_EN to add the registered signed-overflow output ovf.
import pipe_addsub_pkg::*;

module pipe_addsub #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef PIPE_ADDSUB_OVF_EN
    output logic             ovf,
`endif
    output logic [WIDTH:0]   result
);

    localparam int CHUNK = chunk_of(WIDTH, STAGES);

    if (!stages_ok(WIDTH, STAGES)) begin : g_bad_params
        $error("pipe_addsub: WIDTH must be a multiple of STAGES");
    end

    // Index k is the input of stage k; index k+1 is its registered output.
    logic             valid_s [STAGES+1];
    logic [STAGES:0]  ready_s;
    logic [WIDTH-1:0] a_s     [STAGES+1];
    logic [WIDTH-1:0] b_s     [STAGES+1];
    logic [WIDTH-1:0] acc_s   [STAGES+1];
    logic             carry_s [STAGES+1];
    logic             sub_s   [STAGES+1];
    op_e              op_s;

    assign op_s = op_e'(sub);

    // Stage 0 injection: subtraction is a + ~b + 1.
    assign valid_s[0] = in_valid;
    assign a_s[0]     = a;
    assign b_s[0]     = (op_s == OP_SUB) ? ~b : b;
    assign acc_s[0]   = {WIDTH{1'b0}};
    assign carry_s[0] = (op_s == OP_SUB);
    assign sub_s[0]   = (op_s == OP_SUB);

    assign ready_s[STAGES] = out_ready;
    assign in_ready        = ready_s[0] && !rst;

`ifdef PIPE_ADDSUB_OVF_EN
    logic [STAGES-1:0] ovf_s;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        addsub_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (k)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (valid_s[k]),
            .in_ready  (ready_s[k]),
            .in_a      (a_s[k]),
            .in_b      (b_s[k]),
            .in_acc    (acc_s[k]),
            .in_carry  (carry_s[k]),
            .in_sub    (sub_s[k]),
            .out_valid (valid_s[k+1]),
            .out_ready (ready_s[k+1]),
            .out_a     (a_s[k+1]),
            .out_b     (b_s[k+1]),
            .out_acc   (acc_s[k+1]),
            .out_carry (carry_s[k+1]),
`ifdef PIPE_ADDSUB_OVF_EN
            .out_ovf   (ovf_s[k]),
`endif
            .out_sub   (sub_s[k+1])
        );
    end

    // Subtraction reports borrow (inverted carry) in the top bit.
    assign out_valid = valid_s[STAGES];
    assign result    = {carry_s[STAGES] ^ sub_s[STAGES], acc_s[STAGES]};

`ifdef PIPE_ADDSUB_OVF_EN
    assign ovf = ovf_s[STAGES-1];
    logic unused_ovf_s;
    assign unused_ovf_s = &{1'b0, ovf_s};
`endif

    // Operands leaving the last stage are fully consumed.
    logic unused_ops_s;
    assign unused_ops_s = &{1'b0, a_s[STAGES], b_s[STAGES]};

endmodule

// File: tb/tb_pipe_addsub.sv
// Self-checking bench for pipe_addsub (WIDTH=8, STAGES=2).
// Define PIPE_ADDSUB_OVF_EN to also check the ovf output.
module tb_pipe_addsub;

    localparam int W = 8;
    localparam int S = 2;

    typedef struct {
        int         cyc;
        logic [W:0] res;
        logic       ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   result;
`ifdef PIPE_ADDSUB_OVF_EN
    logic         ovf;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   lat_chk = 1'b1;
    bit   have_prev = 1'b0;
    logic [W:0] prev_res;
    exp_t q[$];

    pipe_addsub #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef PIPE_ADDSUB_OVF_EN
        .ovf       (ovf),
`endif
        .result    (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: exact 9-bit result and signed 8-bit overflow.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic s, input int c);
        exp_t e;
        e.cyc = c;
        e.res = s ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
        if (s) e.ovf = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
        else   e.ovf = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
        return e;
    endfunction

    // Scoreboard: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q.delete();
            have_prev = 1'b0;
        end else begin
            if (have_prev) begin
                checks++;
                assert (out_valid === 1'b1 && result === prev_res) else begin
                    errors++;
                    $error("FAIL stall_stable obs=%0b/%h exp=1/%h", out_valid, result, prev_res);
                end
            end
            have_prev = out_valid && !out_ready;
            prev_res  = result;
            if (in_valid && in_ready) q.push_back(model(a, b, sub, cyc));
            if (out_valid && out_ready) begin
                checks++;
                assert (q.size() > 0) else begin
                    errors++;
                    $error("FAIL stale_out obs=%h exp=none", result);
                end
                if (q.size() > 0) begin
                    e = q.pop_front();
                    checks++;
                    assert (result === e.res) else begin
                        errors++;
                        $error("FAIL result obs=%h exp=%h", result, e.res);
                    end
                    if (lat_chk) begin
                        checks++;
                        assert (cyc - e.cyc === S) else begin
                            errors++;
                            $error("FAIL latency obs=%0d exp=%0d", cyc - e.cyc, S);
                        end
                    end
`ifdef PIPE_ADDSUB_OVF_EN
                    checks++;
                    assert (ovf === e.ovf) else begin
                        errors++;
                        $error("FAIL ovf obs=%b exp=%b", ovf, e.ovf);
                    end
`endif
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold the current offer until it is accepted (bounded), then return after that edge.
    task automatic wait_accept(output int waited);
        waited = 0;
        while (waited < 50) begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
        end
        checks++;
        assert (waited < 50) else begin
            errors++;
            $error("FAIL accept_timeout obs=%0d exp=<50", waited);
        end
        step();
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                        output int waited);
        in_valid = 1'b1;
        a = x;
        b = y;
        sub = s;
        wait_accept(waited);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;
    endtask

    task automatic drain();
        int n;
        idle();
        n = 0;
        while ((q.size() != 0 || out_valid) && n < 30) begin
            step();
            n++;
        end
        checks++;
        assert (q.size() === 0) else begin
            errors++;
            $error("FAIL drain obs=%0d exp=0", q.size());
        end
    endtask

    initial begin
        int w;
        rst = 1'b1;
        out_ready = 1'b1;
        idle();
        step();
        step();

        // Reset state
        @(negedge clk);
        checks++;
        assert (in_ready === 1'b0) else begin errors++; $error("FAIL rst_in_ready obs=%b exp=0", in_ready); end
        checks++;
        assert (out_valid === 1'b0) else begin errors++; $error("FAIL rst_out_valid obs=%b exp=0", out_valid); end
        checks++;
        assert (result === 9'h000) else begin errors++; $error("FAIL rst_result obs=%h exp=000", result); end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        assert (in_ready === 1'b1) else begin errors++; $error("FAIL post_rst_ready obs=%b exp=1", in_ready); end
        step();

        // Additions
        send(8'd0,   8'd0,   1'b0, w);
        send(8'd0,   8'd1,   1'b0, w);
        send(8'd0,   8'd255, 1'b0, w);
        send(8'd66,  8'd192, 1'b0, w);
        send(8'd255, 8'd255, 1'b0, w);
        drain();

        // Subtractions, including a borrow
        send(8'd145, 8'd100, 1'b1, w);
        send(8'd50,  8'd100, 1'b1, w);
        send(8'd0,   8'd0,   1'b1, w);
        drain();

        // Back-to-back mixed stream: no wait states
        send(8'd10,  8'd5,   1'b0, w);
        checks++; assert (w === 0) else begin errors++; $error("FAIL stream_ready0 obs=%0d exp=0", w); end
        send(8'd200, 8'd1,   1'b1, w);
        checks++; assert (w === 0) else begin errors++; $error("FAIL stream_ready1 obs=%0d exp=0", w); end
        send(8'd7,   8'd9,   1'b1, w);
        checks++; assert (w === 0) else begin errors++; $error("FAIL stream_ready2 obs=%0d exp=0", w); end
        send(8'd128, 8'd128, 1'b0, w);
        checks++; assert (w === 0) else begin errors++; $error("FAIL stream_ready3 obs=%0d exp=0", w); end
        drain();

        // Backpressure: two fill the pipe, the third must wait
        lat_chk = 1'b0;
        out_ready = 1'b0;
        send(8'd10, 8'd20, 1'b0, w);
        send(8'd3,  8'd4,  1'b1, w);
        in_valid = 1'b1;
        a = 8'd1;
        b = 8'd1;
        sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            assert (in_ready === 1'b0) else begin errors++; $error("FAIL full_in_ready obs=%b exp=0", in_ready); end
            checks++;
            assert (result === 9'h01E) else begin errors++; $error("FAIL full_result obs=%h exp=01e", result); end
        end
        step();
        out_ready = 1'b1;
        wait_accept(w);
        drain();
        lat_chk = 1'b1;

        // Reset with two operations in flight
        send(8'd11, 8'd22, 1'b0, w);
        send(8'd33, 8'd44, 1'b0, w);
        idle();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        assert (in_ready === 1'b0) else begin errors++; $error("FAIL rst_flight_ready obs=%b exp=0", in_ready); end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        assert (out_valid === 1'b0) else begin errors++; $error("FAIL flush_valid obs=%b exp=0", out_valid); end
        checks++;
        assert (result === 9'h000) else begin errors++; $error("FAIL flush_result obs=%h exp=000", result); end
        checks++;
        assert (in_ready === 1'b1) else begin errors++; $error("FAIL flush_ready obs=%b exp=1", in_ready); end
        repeat (4) step();

`ifdef PIPE_ADDSUB_OVF_EN
        // Signed overflow cases
        send(8'd127, 8'd1,  1'b0, w);
        send(8'h80,  8'h01, 1'b1, w);
        send(8'd100, 8'd50, 1'b1, w);
        drain();
`endif

        // Final sweep of pseudo-random operations
        for (int i = 0; i < 20; i++) begin
            send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), w);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
